// File: rtl/spi_pwm_config.sv
// spi_pwm_config: SPI mode-0 write-only slave that owns the PWM control registers.
// The pins are synchronised into clk. Edges are detected on the synchronised values
// and registered as one-cycle strobes. A 16-bit frame is committed on the nCS rising edge.
module spi_pwm_config #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       txn_done,
   output logic       txn_err
);

   logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
   logic                   sclk_s, copi_s, ncs_s;
   logic                   sclk_d, ncs_d;
   // Edges are only trusted once the pipeline holds real pin samples rather than reset
   // values. Without this, an nCS that is low at reset release would look like a falling edge.
   logic [SYNC_STAGES:0]   vld_pipe;
   logic                   hist_ok;
   logic                   sclk_rise_q, ncs_fall_q, ncs_rise_q, copi_q;
   logic [15:0]            shift;
   logic [4:0]             bit_cnt;
   logic                   armed;
   logic                   frame_ok;

   assign sclk_s  = sclk_sync[SYNC_STAGES-1];
   assign copi_s  = copi_sync[SYNC_STAGES-1];
   assign ncs_s   = ncs_sync[SYNC_STAGES-1];
   assign hist_ok = vld_pipe[SYNC_STAGES];

   // Pin synchronisers, reset to the idle bus state (sclk=0, copi=0, ncs=1)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         copi_sync <= '0;
         ncs_sync  <= '1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      end
   end

   // Previous-cycle copies and registered edge strobes; copi is aligned with its sclk strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_d      <= 1'b0;
         ncs_d       <= 1'b1;
         vld_pipe    <= '0;
         sclk_rise_q <= 1'b0;
         ncs_fall_q  <= 1'b0;
         ncs_rise_q  <= 1'b0;
         copi_q      <= 1'b0;
      end else begin
         sclk_d      <= sclk_s;
         ncs_d       <= ncs_s;
         vld_pipe    <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
         sclk_rise_q <= hist_ok & sclk_s & ~sclk_d;
         ncs_fall_q  <= hist_ok & ~ncs_s & ncs_d;
         ncs_rise_q  <= hist_ok & ncs_s & ~ncs_d;
         copi_q      <= copi_s;
      end
   end

   assign frame_ok = (bit_cnt == 5'd16) && shift[15] && (shift[14:8] <= MAX_ADDR);

   // Frame capture and decode. nCS edges take priority over a coincident SCLK edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift           <= '0;
         bit_cnt         <= '0;
         armed           <= 1'b0;
         txn_done        <= 1'b0;
         txn_err         <= 1'b0;
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
      end else begin
         txn_done <= 1'b0;
         txn_err  <= 1'b0;
         if (ncs_fall_q) begin
            bit_cnt <= '0;
            shift   <= '0;
            armed   <= 1'b1;
         end else if (ncs_rise_q) begin
            if (armed) begin
               if (frame_ok) begin
                  case (shift[14:8])
                     7'h00:   en_reg_out_7_0  <= shift[7:0];
                     7'h01:   en_reg_out_15_8 <= shift[7:0];
                     7'h02:   en_reg_pwm_7_0  <= shift[7:0];
                     7'h03:   en_reg_pwm_15_8 <= shift[7:0];
                     7'h04:   pwm_duty_cycle  <= shift[7:0];
                     default: ;
                  endcase
                  txn_done <= 1'b1;
               end else begin
                  txn_err <= 1'b1;
               end
            end
            armed <= 1'b0;
         end else if (sclk_rise_q && armed) begin
            shift <= {shift[14:0], copi_q};
            // Saturate at 17 so any over-length frame stays distinguishable from 16
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

endmodule
